// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light sequencer: state encoding,
// register word addresses, lamp encodings and power-on phase durations.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ALLRED_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } tls_state_t;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_GREEN_T  = 3'd2;
    localparam logic [2:0] ADDR_YELLOW_T = 3'd3;
    localparam logic [2:0] ADDR_ALLRED_T = 3'd4;
    localparam logic [2:0] ADDR_WALK_T   = 3'd5;
    localparam logic [2:0] ADDR_REMAIN   = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int GREEN_T_RST  = 10;
    localparam int YELLOW_T_RST = 3;
    localparam int ALLRED_T_RST = 1;
    localparam int WALK_T_RST   = 5;

    function automatic tls_state_t next_state(input tls_state_t s);
        case (s)
            ALLRED_NS: next_state = NS_GREEN;
            NS_GREEN:  next_state = NS_YELLOW;
            NS_YELLOW: next_state = ALLRED_EW;
            ALLRED_EW: next_state = EW_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            default:   next_state = ALLRED_NS;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp_of(input tls_state_t s);
        case (s)
            NS_GREEN:  ns_lamp_of = LAMP_GRN;
            NS_YELLOW: ns_lamp_of = LAMP_YEL;
            default:   ns_lamp_of = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp_of(input tls_state_t s);
        case (s)
            EW_GREEN:  ew_lamp_of = LAMP_GRN;
            EW_YELLOW: ew_lamp_of = LAMP_YEL;
            default:   ew_lamp_of = LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/tls_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, followed by a one-cycle
// rising-edge pulse. SYNC_STAGES must be at least 2.
module tls_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            last_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~last_reg;

endmodule

// File: rtl/traffic_light_seq.sv
// Avalon-MM two-way intersection sequencer clocked by interval-timer ticks.
// Optional yellow-flash override is built only when TLS_FLASH_EN is defined.
module traffic_light_seq
    import traffic_light_pkg::*;
#(
    parameter int TICK_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        ped_req,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic [2:0]  ns_lamp,
    output logic [2:0]  ew_lamp,
    output logic        ped_walk
);

    logic              tick_d_reg, tick_ev, ped_rise;
    logic              run_reg, irq_en_reg, flash_bit;
    logic              ped_pending_reg, phase_flag_reg;
    logic [TICK_W-1:0] green_t_reg, yellow_t_reg, allred_t_reg, walk_t_reg;
    logic [TICK_W-1:0] remain_reg, remain_next;
    tls_state_t        state_reg, state_next;
    logic              walk_next, advance, walk_start;
    logic [2:0]        ns_next, ew_next;
    logic              wr_en, ctrl_wr, status_wr, run_eff, hold;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[15:TICK_W];

    assign tick_ev   = tick & ~tick_d_reg;
    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    // A CTRL write acts on the sequencer in the same edge it is captured
    assign run_eff   = ctrl_wr ? writedata[0] : run_reg;
    assign irq       = phase_flag_reg & irq_en_reg;

    tls_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ped_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (ped_req),
        .rise     (ped_rise)
    );

    function automatic logic [TICK_W-1:0] load_val(input logic [TICK_W-1:0] d);
        load_val = (d == '0) ? TICK_W'(1) : d;
    endfunction

    function automatic logic [TICK_W-1:0] dur_of(input tls_state_t s,
                                                  input logic [TICK_W-1:0] g,
                                                  input logic [TICK_W-1:0] y,
                                                  input logic [TICK_W-1:0] a);
        case (s)
            NS_GREEN, EW_GREEN:   dur_of = g;
            NS_YELLOW, EW_YELLOW: dur_of = y;
            default:              dur_of = a;
        endcase
    endfunction

`ifdef TLS_FLASH_EN
    logic flash_reg, flash_on_reg, flash_on_next, flash_eff;
    assign flash_eff = ctrl_wr ? writedata[2] : flash_reg;
    assign flash_bit = flash_reg;
    assign hold      = flash_eff | ~run_eff;
    always_comb begin
        flash_on_next = 1'b1;
        if (flash_eff && flash_reg)
            flash_on_next = tick_ev ? ~flash_on_reg : flash_on_reg;
    end
`else
    assign flash_bit = 1'b0;
    assign hold      = ~run_eff;
`endif

    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        walk_next   = ped_walk;
        advance     = 1'b0;
        walk_start  = 1'b0;
        if (hold) begin
            state_next  = ALLRED_NS;
            remain_next = load_val(allred_t_reg);
            walk_next   = 1'b0;
        end else if (tick_ev) begin
            if (remain_reg <= TICK_W'(1)) begin
                advance     = 1'b1;
                state_next  = next_state(state_reg);
                walk_start  = (state_next == ALLRED_EW) && ped_pending_reg;
                remain_next = walk_start ? load_val(walk_t_reg)
                                         : load_val(dur_of(state_next, green_t_reg,
                                                           yellow_t_reg, allred_t_reg));
                walk_next   = walk_start;
            end else begin
                remain_next = remain_reg - TICK_W'(1);
            end
        end
        ns_next = ns_lamp_of(state_next);
        ew_next = ew_lamp_of(state_next);
`ifdef TLS_FLASH_EN
        if (flash_eff) begin
            ns_next = flash_on_next ? LAMP_YEL : LAMP_OFF;
            ew_next = flash_on_next ? LAMP_YEL : LAMP_OFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d_reg      <= 1'b0;
            state_reg       <= ALLRED_NS;
            remain_reg      <= TICK_W'(ALLRED_T_RST);
            ns_lamp         <= LAMP_RED;
            ew_lamp         <= LAMP_RED;
            ped_walk        <= 1'b0;
            ped_pending_reg <= 1'b0;
            phase_flag_reg  <= 1'b0;
        end else begin
            tick_d_reg <= tick;
            state_reg  <= state_next;
            remain_reg <= remain_next;
            ns_lamp    <= ns_next;
            ew_lamp    <= ew_next;
            ped_walk   <= walk_next;
            // A request arriving in the same cycle as walk entry is kept for the next round
            if (ped_rise)
                ped_pending_reg <= 1'b1;
            else if (walk_start)
                ped_pending_reg <= 1'b0;
            if (advance)
                phase_flag_reg <= 1'b1;
            else if (status_wr)
                phase_flag_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg      <= 1'b0;
            irq_en_reg   <= 1'b0;
            green_t_reg  <= TICK_W'(GREEN_T_RST);
            yellow_t_reg <= TICK_W'(YELLOW_T_RST);
            allred_t_reg <= TICK_W'(ALLRED_T_RST);
            walk_t_reg   <= TICK_W'(WALK_T_RST);
            readdata     <= '0;
`ifdef TLS_FLASH_EN
            flash_reg    <= 1'b0;
            flash_on_reg <= 1'b1;
`endif
        end else begin
`ifdef TLS_FLASH_EN
            flash_on_reg <= flash_on_next;
            if (ctrl_wr)
                flash_reg <= writedata[2];
`endif
            if (ctrl_wr) begin
                run_reg    <= writedata[0];
                irq_en_reg <= writedata[1];
            end
            if (wr_en && address == ADDR_GREEN_T)  green_t_reg  <= writedata[TICK_W-1:0];
            if (wr_en && address == ADDR_YELLOW_T) yellow_t_reg <= writedata[TICK_W-1:0];
            if (wr_en && address == ADDR_ALLRED_T) allred_t_reg <= writedata[TICK_W-1:0];
            if (wr_en && address == ADDR_WALK_T)   walk_t_reg   <= writedata[TICK_W-1:0];
            case (address)
                ADDR_CTRL:     readdata <= {13'b0, flash_bit, irq_en_reg, run_reg};
                ADDR_STATUS:   readdata <= {11'b0, phase_flag_reg, ped_pending_reg, state_reg};
                ADDR_GREEN_T:  readdata <= 16'(green_t_reg);
                ADDR_YELLOW_T: readdata <= 16'(yellow_t_reg);
                ADDR_ALLRED_T: readdata <= 16'(allred_t_reg);
                ADDR_WALK_T:   readdata <= 16'(walk_t_reg);
                ADDR_REMAIN:   readdata <= 16'(remain_reg);
                default:       readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_seq.sv
// Directed bench for traffic_light_seq: table-driven phase walk plus
// hand-written sequences for tick hold, pedestrian, irq, run-clear and reset.
module tb_traffic_light_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        ped_req = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;
    logic [2:0]  ns_lamp, ew_lamp;
    logic        ped_walk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .ped_req    (ped_req),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .ped_walk   (ped_walk)
    );

    typedef struct {
        int          n_ticks;
        logic [2:0]  st;
        logic [15:0] rem;
        logic [2:0]  ns;
        logic [2:0]  ew;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] st, input logic [15:0] rem);
        logic [15:0] d;
        bus_read(3'd1, d);
        check({name, ".state"}, {13'd0, d[2:0]}, {13'd0, st});
        bus_read(3'd6, d);
        check({name, ".remain"}, d, rem);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;

        vecs[0]  = '{1, 3'd1, 16'd10, 3'b001, 3'b100};
        vecs[1]  = '{9, 3'd1, 16'd1,  3'b001, 3'b100};
        vecs[2]  = '{1, 3'd2, 16'd3,  3'b010, 3'b100};
        vecs[3]  = '{2, 3'd2, 16'd1,  3'b010, 3'b100};
        vecs[4]  = '{1, 3'd3, 16'd1,  3'b100, 3'b100};
        vecs[5]  = '{1, 3'd4, 16'd10, 3'b100, 3'b001};
        vecs[6]  = '{9, 3'd4, 16'd1,  3'b100, 3'b001};
        vecs[7]  = '{1, 3'd5, 16'd3,  3'b100, 3'b010};
        vecs[8]  = '{2, 3'd5, 16'd1,  3'b100, 3'b010};
        vecs[9]  = '{1, 3'd0, 16'd1,  3'b100, 3'b100};
        vecs[10] = '{1, 3'd1, 16'd10, 3'b001, 3'b100};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.readdata", readdata, 16'd0);
        check("rst.irq", {15'd0, irq}, 16'd0);
        check("rst.ns_lamp", {13'd0, ns_lamp}, 16'd4);
        check("rst.ew_lamp", {13'd0, ew_lamp}, 16'd4);
        check("rst.ped_walk", {15'd0, ped_walk}, 16'd0);
        reset_n = 1'b1;
        bus_read(3'd0, d); check("rst.ctrl", d, 16'd0);
        bus_read(3'd1, d); check("rst.status", d, 16'd0);
        bus_read(3'd2, d); check("rst.green_t", d, 16'd10);
        bus_read(3'd3, d); check("rst.yellow_t", d, 16'd3);
        bus_read(3'd4, d); check("rst.allred_t", d, 16'd1);
        bus_read(3'd5, d); check("rst.walk_t", d, 16'd5);
        bus_read(3'd6, d); check("rst.remain", d, 16'd1);
        bus_read(3'd7, d); check("rst.addr7", d, 16'd0);

        // Full cycle driven from the vector table
        bus_write(3'd0, 16'h0001);
        for (int v = 0; v < 11; v++) begin
            ticks(vecs[v].n_ticks);
            check($sformatf("vec%0d.ns", v), {13'd0, ns_lamp}, {13'd0, vecs[v].ns});
            check($sformatf("vec%0d.ew", v), {13'd0, ew_lamp}, {13'd0, vecs[v].ew});
            check_state($sformatf("vec%0d", v), vecs[v].st, vecs[v].rem);
        end

        // Tick held high counts once
        @(negedge clk); tick = 1'b1;
        repeat (50) @(negedge clk);
        tick = 1'b0;
        check_state("hold", 3'd1, 16'd9);

        // Pedestrian request during NS_GREEN
        @(negedge clk); ped_req = 1'b1;
        repeat (2) @(negedge clk); ped_req = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(3'd1, d); check("ped.pending_before", {15'd0, d[3]}, 16'd1);
        ticks(9);
        check_state("ped.yellow", 3'd2, 16'd3);
        ticks(3);
        check("ped.walk_on", {15'd0, ped_walk}, 16'd1);
        check("ped.ns_red", {13'd0, ns_lamp}, 16'd4);
        check("ped.ew_red", {13'd0, ew_lamp}, 16'd4);
        bus_read(3'd1, d); check("ped.pending_after", {15'd0, d[3]}, 16'd0);
        check_state("ped.entry", 3'd3, 16'd5);
        ticks(4);
        check("ped.walk_hold", {15'd0, ped_walk}, 16'd1);
        check_state("ped.last", 3'd3, 16'd1);
        ticks(1);
        check("ped.walk_off", {15'd0, ped_walk}, 16'd0);
        check_state("ped.exit", 3'd4, 16'd10);

        // GREEN_T=0, irq behaviour
        bus_write(3'd2, 16'h0000);
        bus_write(3'd0, 16'h0003);
        bus_write(3'd1, 16'h0000);
        check("irq.cleared", {15'd0, irq}, 16'd0);
        bus_read(3'd6, d); check("irq.phase_unaffected", d, 16'd10);
        ticks(10);
        check("irq.rise1", {15'd0, irq}, 16'd1);
        bus_write(3'd1, 16'h0000);
        check("irq.clear1", {15'd0, irq}, 16'd0);
        ticks(4);
        check_state("zero.green", 3'd1, 16'd1);
        bus_write(3'd1, 16'h0000);
        ticks(1);
        check("irq.rise2", {15'd0, irq}, 16'd1);
        check_state("zero.after", 3'd2, 16'd3);
        bus_write(3'd1, 16'h0000);
        check("irq.clear2", {15'd0, irq}, 16'd0);
        ticks(2);
        @(negedge clk);
        tick = 1'b1; address = 3'd1; writedata = 16'h0000; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        check("irq.set_wins", {15'd0, irq}, 16'd1);
        check("irq.no_walk", {15'd0, ped_walk}, 16'd0);
        check_state("irq.adv", 3'd3, 16'd1);

        // run cleared mid-EW_GREEN
        bus_write(3'd2, 16'd10);
        ticks(1);
        check("run.ew_green", {13'd0, ew_lamp}, 16'd1);
        ticks(3);
        check_state("run.mid", 3'd4, 16'd7);
        bus_write(3'd0, 16'h0002);
        check("run.ns_red", {13'd0, ns_lamp}, 16'd4);
        check("run.ew_red", {13'd0, ew_lamp}, 16'd4);
        check_state("run.stop", 3'd0, 16'd1);
        ticks(3);
        check("run.ignored_ns", {13'd0, ns_lamp}, 16'd4);
        check_state("run.ignored", 3'd0, 16'd1);

        // CTRL bit 2
        bus_write(3'd0, 16'h0007);
`ifdef TLS_FLASH_EN
        bus_read(3'd0, d); check("ctrl.flash_read", d, 16'd7);
        check("flash.ns_on", {13'd0, ns_lamp}, 16'd2);
        check("flash.ew_on", {13'd0, ew_lamp}, 16'd2);
        ticks(1);
        check("flash.ns_off", {13'd0, ns_lamp}, 16'd0);
        ticks(1);
        check("flash.ns_on2", {13'd0, ns_lamp}, 16'd2);
`else
        bus_read(3'd0, d); check("ctrl.flash_read", d, 16'd3);
        ticks(1);
        check("ctrl.resume_ns", {13'd0, ns_lamp}, 16'd1);
`endif

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset.ns", {13'd0, ns_lamp}, 16'd4);
        check("areset.ew", {13'd0, ew_lamp}, 16'd4);
        check("areset.walk", {15'd0, ped_walk}, 16'd0);
        check("areset.irq", {15'd0, irq}, 16'd0);
        check("areset.readdata", readdata, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_seq.md
Name: traffic_light_seq

Overview:
Avalon-MM slave that consumes the interval timer's timeout output as its time base and sequences a two-way intersection: north-south, east-west and a pedestrian walk lamp. It sits directly downstream of the interval timer. The timer's irq (or timeout pulse) feeds `tick`. NIOS II software sets the phase durations and receives a per-phase-change interrupt.

Parameters:
- TICK_W, 8, width of the duration and remaining-count registers (max 255 ticks per phase)
- SYNC_STAGES, 2, flip-flop stages in the ped_req synchronizer

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  timer timeout level/pulse, same clock domain; rising edge = one tick
- ped_req  in  1  asynchronous pedestrian push-button, active-high
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  phase-change interrupt, level
- ns_lamp  out  3  {red, yellow, green} north-south
- ew_lamp  out  3  {red, yellow, green} east-west
- ped_walk  out  1  pedestrian walk lamp

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is reset_n, asynchronous, active-low.
  - Reset values: readdata=0, irq=0, ns_lamp=3'b100, ew_lamp=3'b100, ped_walk=0, state=ALLRED_NS.
- Register map (word addresses):
  - 0 CTRL RW: [0] run, [1] irq_en, [2] flash (optional). Reset 0.
  - 1 STATUS: read {11'b0, phase_flag[4], ped_pending[3], state[2:0]}; any write clears phase_flag.
  - 2 GREEN_T, reset 10; 3 YELLOW_T, reset 3; 4 ALLRED_T, reset 1; 5 WALK_T, reset 5. All RW [TICK_W-1:0]; upper bits read 0.
  - 6 REMAIN RO, current remaining count.
  - 7 reads 0.
- Read timing:
  - readdata registered every cycle from the address mux; 1-cycle latency, no wait states.
- Tick handling:
  - tick_ev = tick & ~tick_d, where tick_d is a 1-cycle delayed copy.
  - A timer irq held high yields exactly one event.
- State machine (encoding 0..5), order ALLRED_NS → NS_GREEN → NS_YELLOW → ALLRED_EW → EW_GREEN → EW_YELLOW → ALLRED_NS:
  - Lamps: ALLRED_* both red; NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_* mirrored.
- Count and advance:
  - On tick_ev with run=1: if remain ≤ 1, advance to the next state and load remain with the next state's duration; otherwise remain decrements by 1.
  - A duration register value of 0 loads as 1.
  - Duration writes take effect at the next load only; the phase in progress is unaffected.
- Pedestrian request:
  - ped_req is synchronized (SYNC_STAGES) and rising-edge detected; the edge sets ped_pending.
  - On entry to ALLRED_EW with ped_pending=1: load WALK_T instead of ALLRED_T, drive ped_walk=1 for the whole phase, and clear ped_pending in the same cycle.
  - A new request during the walk phase sets ped_pending again, for the next cycle of the sequence.
- run=0:
  - State forced to ALLRED_NS and remain=ALLRED_T; ticks ignored; ped_pending retained.
  - Clearing run mid-phase aborts immediately: lamps go all-red on the next clk.
- phase_flag:
  - Set on every state advance.
  - A STATUS write in the same cycle as an advance leaves phase_flag=1 (set wins).
  - irq = phase_flag & irq_en, combinational from registers.
- Reset mid-operation returns all outputs to the reset values asynchronously.

Optional Feature:
- TLS_FLASH_EN defined:
  - CTRL[2]=1 overrides run: both yellow lamps on, others off, toggling on each tick_ev; ped_walk=0.
  - FSM is held at ALLRED_NS; on clearing flash, the sequence resumes from ALLRED_NS with remain reloaded.
- TLS_FLASH_EN undefined:
  - CTRL[2] is not stored, reads 0 and has no effect.

Decomposition:
- Shared package traffic_light_pkg contains:
  - the state enum (ALLRED_NS..EW_YELLOW);
  - register address constants;
  - lamp-encoding constants (LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001);
  - reset duration constants.
- One sub-module, tls_sync_edge: SYNC_STAGES-deep synchronizer plus rising-edge pulse, used for ped_req.

Test Plan:
- Reset, run=1, tick pulse every 4 clk → states 0,1,2,3,4,5,0 with dwell 1,10,3,1,10,3 ticks; ns_lamp=001 only in state 1.
- tick held high 50 clk → exactly one decrement; REMAIN read shows 9 during NS_GREEN.
- ped_req pulse during NS_GREEN → ALLRED_EW lasts 5 ticks with ped_walk=1; STATUS[3] reads 1 before entry and 0 after.
- GREEN_T=0 written, irq_en=1 → green lasts 1 tick; irq rises on each advance; STATUS write in the same cycle as an advance → irq stays 1.
- run cleared mid-EW_GREEN → next clk both lamps 100, state=0, REMAIN=1; further ticks ignored.
- With TLS_FLASH_EN, CTRL=4 → lamps alternate 010/000 per tick; without the macro, CTRL read after writing 7 returns 3.
